// File: rtl/sfq_rx_pkg.sv
// rtl/sfq_rx_pkg.sv - shared types and helpers for the SFQ NOTT receiver
package sfq_rx_pkg;

  // Window FSM states
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_WINDOW = 1'b1
  } rx_state_e;

  // Timing violation kinds, used as bit positions in the violation vector
  typedef enum logic [1:0] {
    VIOL_EARLY  = 2'd0,
    VIOL_DOUBLE = 2'd1,
    VIOL_STRAY  = 2'd2,
    VIOL_CLOCK  = 2'd3
  } viol_e;

  localparam int unsigned VIOL_N = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ERR_W  = 16;

  // Saturating increment for the error counter
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + {{(ERR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/sfq_toggle_sync.sv
// rtl/sfq_toggle_sync.sv - toggle-line synchronizer with post-reset mask and event detect
module sfq_toggle_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic event_o
);

  localparam int unsigned MASK_CYC = SYNC_STAGES + 1;
  localparam int unsigned MASK_W   = $clog2(MASK_CYC + 1);
  localparam logic [MASK_W-1:0] MASK_DONE = MASK_W'(MASK_CYC);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [MASK_W-1:0]      mask_cnt_q;
  logic                   level;
  logic                   masked;

  assign level   = sync_q[SYNC_STAGES-1];
  assign masked  = (mask_cnt_q != MASK_DONE);
  // Every change of the synchronized level is one pulse; ignore the settling
  // period after reset while the chain fills with the true line level.
  assign event_o = (level ^ prev_q) & ~masked;

  // Synchronizer chain and previous-level tracking (tracks even while masked)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= line_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= level;
    end
  end

  // Post-reset mask counter, stops once the chain has settled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_cnt_q <= '0;
    end else if (masked) begin
      mask_cnt_q <= mask_cnt_q + {{(MASK_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/sfq_nott_rx.sv
// rtl/sfq_nott_rx.sv - SFQ NOTT receiver: windowed bit decision, word deserializer, error tracking
module sfq_nott_rx
  import sfq_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WIN_MIN     = 2,
  parameter int unsigned WIN_MAX     = 6,
  parameter int unsigned WORD_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sfq_clk_i,
  input  logic              sfq_q_i,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_data_o,
  input  logic              word_ready_i,
  output logic              timing_err_o,
  output logic              overrun_o,
  output logic [ERR_W-1:0]  err_count_o
);

  localparam logic [CNT_W-1:0] WMIN = CNT_W'(WIN_MIN);
  localparam logic [CNT_W-1:0] WMAX = CNT_W'(WIN_MAX);
  localparam int unsigned      BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

  logic clk_ev;
  logic q_ev;

  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hit_q;
  logic             emit_q;
  logic             emit_bit_q;

  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] shift_d;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic              word_done;
  logic              word_valid_q;
  logic [WORD_W-1:0] word_data_q;
  logic              overrun_q;
  logic              timing_err_q;
  logic [ERR_W-1:0]  err_cnt_q;

  logic              active;
  logic [CNT_W-1:0]  eff_cnt;
  logic              hit_base;
  logic              q_early;
  logic              q_acc;
  logic              hit_d;
  logic              at_end;
  logic [VIOL_N-1:0] viol_d;

  sfq_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_i  (sfq_clk_i),
    .event_o (clk_ev)
  );

  sfq_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_q_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_i  (sfq_q_i),
    .event_o (q_ev)
  );

  // Classify this cycle's q event; a clk event restarts the window first,
  // so a coincident q is judged at counter 0 of the new window.
  always_comb begin
    active   = 1'b0;
    eff_cnt  = '0;
    hit_base = 1'b0;
    if (clk_ev) begin
      active = 1'b1;
    end else if (state_q == ST_WINDOW) begin
      active   = 1'b1;
      eff_cnt  = cnt_q;
      hit_base = hit_q;
    end
    q_early = q_ev && active && (eff_cnt < WMIN);
    q_acc   = q_ev && active && !(eff_cnt < WMIN) && (eff_cnt <= WMAX);
    hit_d   = hit_base | q_acc;
    at_end  = active && (eff_cnt == WMAX);
    viol_d              = '0;
    viol_d[VIOL_EARLY]  = q_early;
    viol_d[VIOL_DOUBLE] = q_acc && hit_base;
    viol_d[VIOL_STRAY]  = q_ev && !active;
    viol_d[VIOL_CLOCK]  = clk_ev && (state_q == ST_WINDOW);
  end

  // Window FSM: counts the acceptance window and emits one registered bit per window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hit_q      <= 1'b0;
      emit_q     <= 1'b0;
      emit_bit_q <= 1'b0;
    end else begin
      emit_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (clk_ev) begin
            if (at_end) begin
              emit_q     <= 1'b1;
              emit_bit_q <= hit_d;
            end else begin
              state_q <= ST_WINDOW;
              cnt_q   <= eff_cnt + 8'd1;
              hit_q   <= hit_d;
            end
          end
        end
        ST_WINDOW: begin
          if (clk_ev) begin
            // Early clock: close the old window with what it had so far
            emit_q     <= 1'b1;
            emit_bit_q <= hit_q;
            cnt_q      <= eff_cnt + 8'd1;
            hit_q      <= hit_d;
          end else if (at_end) begin
            emit_q     <= 1'b1;
            emit_bit_q <= hit_d;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hit_q      <= 1'b0;
          end else begin
            cnt_q <= eff_cnt + 8'd1;
            hit_q <= hit_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // First received bit ends up at the LSB once the word is complete
  always_comb begin
    shift_d             = shift_q >> 1;
    shift_d[WORD_W-1]   = emit_bit_q;
  end

  assign word_done = emit_q && (bit_cnt_q == BIT_LAST);

  // Deserializer and output holding register with drop-on-overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      if (emit_q) begin
        shift_q   <= shift_d;
        bit_cnt_q <= word_done ? '0 : bit_cnt_q + {{(BIT_W-1){1'b0}}, 1'b1};
      end
      if (word_done && (!word_valid_q || word_ready_i)) begin
        word_data_q  <= shift_d;
        word_valid_q <= 1'b1;
      end else begin
        if (word_valid_q && word_ready_i) begin
          word_valid_q <= 1'b0;
        end
        if (word_done) begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  // Error pulse and saturating count; simultaneous violations count once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timing_err_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      timing_err_q <= |viol_d;
      if (|viol_d) begin
        err_cnt_q <= sat_inc(err_cnt_q);
      end
    end
  end

  assign word_valid_o = word_valid_q;
  assign word_data_o  = word_data_q;
  assign timing_err_o = timing_err_q;
  assign overrun_o    = overrun_q;
  assign err_count_o  = err_cnt_q;

endmodule

// File: tb/tb_sfq_nott_rx.sv
// tb/tb_sfq_nott_rx.sv - self-checking bench for sfq_nott_rx against an interval-based window model
module tb_sfq_nott_rx;

  localparam int SYNC = 2;
  localparam int WMIN = 2;
  localparam int WMAX = 6;
  localparam int WW   = 8;
  localparam int MAXC = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sfq_clk_i = 1'b0;
  logic          sfq_q_i = 1'b0;
  logic          word_ready_i = 1'b0;
  logic          word_valid_o;
  logic [WW-1:0] word_data_o;
  logic          timing_err_o;
  logic          overrun_o;
  logic [15:0]   err_count_o;

  always #5 clk = ~clk;

  sfq_nott_rx #(
    .SYNC_STAGES (SYNC),
    .WIN_MIN     (WMIN),
    .WIN_MAX     (WMAX),
    .WORD_W      (WW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sfq_clk_i    (sfq_clk_i),
    .sfq_q_i      (sfq_q_i),
    .word_valid_o (word_valid_o),
    .word_data_o  (word_data_o),
    .word_ready_i (word_ready_i),
    .timing_err_o (timing_err_o),
    .overrun_o    (overrun_o),
    .err_count_o  (err_count_o)
  );

  int n_checks = 0;
  int n_fails  = 0;

  bit sc_clk [MAXC];
  bit sc_q   [MAXC];
  bit sc_rdy [MAXC];
  int sc_len;

  logic [WW-1:0] got_words [$];
  logic [WW-1:0] exp_words [$];
  int pulse_cnt;
  int first_valid;
  int exp_viol;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_sched();
    for (int i = 0; i < MAXC; i++) begin
      sc_clk[i] = 1'b0;
      sc_q[i]   = 1'b0;
      sc_rdy[i] = 1'b1;
    end
    sc_len = 0;
    got_words.delete();
    pulse_cnt   = 0;
    first_valid = -1;
  endtask

  task automatic do_reset(input logic lvl);
    @(negedge clk);
    rst_n        = 1'b0;
    sfq_clk_i    = lvl;
    sfq_q_i      = lvl;
    word_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_sched();
  endtask

  // Index i of the schedule is the negedge at which the toggle is driven
  task automatic run_sched();
    for (int i = 0; i < sc_len; i++) begin
      @(negedge clk);
      if (sc_clk[i]) sfq_clk_i = ~sfq_clk_i;
      if (sc_q[i])   sfq_q_i   = ~sfq_q_i;
      word_ready_i = sc_rdy[i];
      if (timing_err_o) pulse_cnt++;
      if (word_valid_o && first_valid < 0) first_valid = i;
      if (word_valid_o && word_ready_i) got_words.push_back(word_data_o);
    end
  endtask

  // Reference: every clk event opens a window [T, T+WIN_MAX], cut short by the
  // next clk event; q events are classified by their offset in the owning window.
  task automatic run_model();
    int ct [$];
    int qt [$];
    int wend [$];
    bit whit [$];
    int wacc [$];
    bit vmark [MAXC];
    logic [WW-1:0] acc;
    int nb;
    exp_words.delete();
    exp_viol = 0;
    acc = '0;
    nb = 0;
    for (int i = 0; i < MAXC; i++) vmark[i] = 1'b0;
    for (int i = 0; i < sc_len; i++) begin
      if (sc_clk[i]) ct.push_back(i);
      if (sc_q[i])   qt.push_back(i);
    end
    foreach (ct[k]) begin
      int e;
      e = ct[k] + WMAX;
      if (k + 1 < ct.size() && ct[k+1] <= e) begin
        e = ct[k+1] - 1;
        vmark[ct[k+1]] = 1'b1;
      end
      wend.push_back(e);
      whit.push_back(1'b0);
      wacc.push_back(0);
    end
    foreach (qt[j]) begin
      int s;
      int w;
      s = qt[j];
      w = -1;
      foreach (ct[k]) if (ct[k] <= s) w = k;
      if (w < 0 || s > wend[w]) vmark[s] = 1'b1;
      else if (s - ct[w] < WMIN) vmark[s] = 1'b1;
      else begin
        if (wacc[w] > 0) vmark[s] = 1'b1;
        wacc[w]++;
        whit[w] = 1'b1;
      end
    end
    foreach (whit[k]) begin
      acc[nb] = whit[k];
      nb++;
      if (nb == WW) begin
        exp_words.push_back(acc);
        nb = 0;
      end
    end
    for (int i = 0; i < MAXC; i++) if (vmark[i]) exp_viol++;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, "_nwords"}, got_words.size(), exp_words.size());
    foreach (exp_words[k]) begin
      check_eq($sformatf("%s_word%0d", tag, k),
               (k < got_words.size()) ? 32'(got_words[k]) : 32'hDEAD, 32'(exp_words[k]));
    end
    check_eq({tag, "_errcnt"}, err_count_o, exp_viol);
    check_eq({tag, "_pulses"}, pulse_cnt, exp_viol);
    check_eq({tag, "_overrun"}, overrun_o, 0);
  endtask

  initial begin
    // Reset state
    do_reset(1'b0);
    check_eq("rst_valid", word_valid_o, 0);
    check_eq("rst_data", word_data_o, 0);
    check_eq("rst_terr", timing_err_o, 0);
    check_eq("rst_overrun", overrun_o, 0);
    check_eq("rst_errcnt", err_count_o, 0);

    // Eight windows, q 4 cycles after clk in windows 0, 2, 7; word held
    for (int w = 0; w < 8; w++) begin
      sc_clk[6 + 10*w] = 1'b1;
      if (w == 0 || w == 2 || w == 7) sc_q[10 + 10*w] = 1'b1;
    end
    for (int i = 0; i < MAXC; i++) sc_rdy[i] = 1'b0;
    sc_len = 110;
    run_sched();
    check_eq("w85_data", word_data_o, 8'h85);
    check_eq("w85_valid", word_valid_o, 1);
    check_eq("w85_errcnt", err_count_o, 0);
    check_eq("w85_pulses", pulse_cnt, 0);
    check_eq("w85_latency", first_valid, 76 + SYNC + WMAX + 2);

    // Early q at counter 1
    do_reset(1'b0);
    for (int w = 0; w < 8; w++) sc_clk[6 + 10*w] = 1'b1;
    sc_q[7] = 1'b1;
    for (int i = 0; i < MAXC; i++) sc_rdy[i] = 1'b0;
    sc_len = 110;
    run_sched();
    check_eq("early_data", word_data_o, 8'h00);
    check_eq("early_valid", word_valid_o, 1);
    check_eq("early_errcnt", err_count_o, 1);
    check_eq("early_pulses", pulse_cnt, 1);

    // Clock at counter 3 after hit, WIN_MAX and WIN_MIN edges, stray q
    do_reset(1'b0);
    sc_clk[6] = 1'b1; sc_q[8] = 1'b1; sc_clk[9] = 1'b1; sc_q[15] = 1'b1;
    for (int w = 0; w < 6; w++) sc_clk[19 + 10*w] = 1'b1;
    sc_q[21] = 1'b1; sc_q[36] = 1'b1;
    for (int i = 0; i < MAXC; i++) sc_rdy[i] = 1'b0;
    sc_len = 100;
    run_sched();
    check_eq("clkv_data", word_data_o, 8'h07);
    check_eq("clkv_errcnt", err_count_o, 2);
    check_eq("clkv_latency", first_valid, 69 + SYNC + WMAX + 2);

    // Overrun: two words complete with no consumer
    do_reset(1'b0);
    for (int w = 0; w < 16; w++) begin
      sc_clk[6 + 10*w] = 1'b1;
      if (w == 0 || w >= 8) sc_q[10 + 10*w] = 1'b1;
    end
    for (int i = 0; i < MAXC; i++) sc_rdy[i] = 1'b0;
    sc_len = 190;
    run_sched();
    check_eq("ovr_data", word_data_o, 8'h01);
    check_eq("ovr_valid", word_valid_o, 1);
    check_eq("ovr_flag", overrun_o, 1);
    @(negedge clk); word_ready_i = 1'b1;
    @(negedge clk); word_ready_i = 1'b0;
    check_eq("ovr_consumed", word_valid_o, 0);
    check_eq("ovr_sticky", overrun_o, 1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_overrun", overrun_o, 0);
    check_eq("async_rst_data", word_data_o, 0);

    // Lines held high across reset release
    do_reset(1'b1);
    sc_len = 40;
    run_sched();
    check_eq("high_valid", word_valid_o, 0);
    check_eq("high_errcnt", err_count_o, 0);
    check_eq("high_pulses", pulse_cnt, 0);
    clear_sched();
    for (int w = 0; w < 8; w++) sc_clk[6 + 10*w] = 1'b1;
    sc_q[20] = 1'b1;
    sc_len = 110;
    run_sched();
    run_model();
    compare_all("high");
    check_eq("high_word", (got_words.size() > 0) ? 32'(got_words[0]) : 32'hDEAD, 8'h02);

    // Reset mid-word and mid-window discards partial state
    do_reset(1'b0);
    for (int w = 0; w < 4; w++) begin
      sc_clk[6 + 10*w] = 1'b1;
      sc_q[10 + 10*w]  = 1'b1;
    end
    sc_len = 40;
    run_sched();
    do_reset(1'b0);
    check_eq("midrst_errcnt", err_count_o, 0);
    for (int w = 0; w < 8; w++) sc_clk[6 + 10*w] = 1'b1;
    sc_q[10] = 1'b1;
    sc_len = 110;
    run_sched();
    run_model();
    compare_all("midrst");
    check_eq("midrst_word", (got_words.size() > 0) ? 32'(got_words[0]) : 32'hDEAD, 8'h01);

    // Randomized event streams against the model
    for (int r = 0; r < 4; r++) begin
      do_reset(1'($urandom_range(0, 1)));
      sc_len = 420;
      for (int i = 6; i < sc_len - 25; i++) begin
        sc_clk[i] = ($urandom_range(0, 5) == 0);
        sc_q[i]   = ($urandom_range(0, 3) == 0);
      end
      run_sched();
      run_model();
      compare_all($sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
